// File: rtl/audio_onset_detector_if.sv
// Read side of the audio codec input FIFO: sample-available flag, stereo
// sample pair and the one-cycle pop strobe.
interface audio_onset_detector_if #(
   parameter int SAMPLE_W = 32
);
   logic                audio_in_available;
   logic [SAMPLE_W-1:0] left_channel_audio_in;
   logic [SAMPLE_W-1:0] right_channel_audio_in;
   logic                read_audio_in;

   // FIFO side: presents samples, receives the pop strobe
   modport master (
      output audio_in_available,
      output left_channel_audio_in,
      output right_channel_audio_in,
      input  read_audio_in
   );

   // Consumer side: the onset detector
   modport slave (
      input  audio_in_available,
      input  left_channel_audio_in,
      input  right_channel_audio_in,
      output read_audio_in
   );
endinterface

// File: rtl/audio_onset_detector.sv
// Audio onset detector: stereo sample -> mono magnitude -> attack/release
// envelope -> hysteresis threshold with a per-sample holdoff, producing
// single-cycle onset pulses plus envelope, peak and onset-count readouts.
module audio_onset_detector #(
   parameter int                  SAMPLE_W      = 32,
   parameter int                  ATTACK_SHIFT  = 2,
   parameter int                  RELEASE_SHIFT = 8,
   parameter logic [SAMPLE_W-1:0] THRESH_ON     = SAMPLE_W'(20000000),
   parameter logic [SAMPLE_W-1:0] THRESH_OFF    = SAMPLE_W'(10000000),
   parameter logic [15:0]         HOLDOFF       = 16'd4800
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   clear_peak,
   audio_onset_detector_if.slave  fifo,
   output logic                   onset,
   output logic                   active,
   output logic [SAMPLE_W-1:0]    envelope,
   output logic [SAMPLE_W-1:0]    peak_level,
   output logic [15:0]            onset_count
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] MIX    = 2'd1;
   localparam logic [1:0] ENV    = 2'd2;
   localparam logic [1:0] DETECT = 2'd3;

   localparam logic [SAMPLE_W-1:0] NEG_FULL = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic [SAMPLE_W-1:0] POS_FULL = {1'b0, {(SAMPLE_W-1){1'b1}}};

   logic [1:0]          state_q, state_d;
   logic [SAMPLE_W-1:0] l_q, l_d, r_q, r_d;
   logic [SAMPLE_W-1:0] mag_q, mag_d;
   logic [SAMPLE_W-1:0] peak_q, peak_d;
   logic [SAMPLE_W-1:0] env_q, env_d;
   logic                onset_q, onset_d;
   logic                active_q, active_d;
   logic [15:0]         holdoff_q, holdoff_d;
   logic [15:0]         count_q, count_d;

   logic                       rd;
   logic signed [SAMPLE_W-1:0] mix;
   logic [SAMPLE_W-1:0]        mag_c;
   logic [SAMPLE_W:0]          ext_mag, ext_env;

   // Pop strobe is combinational so the sample is latched in the same cycle
   always_comb begin
      rd = (state_q == IDLE) && enable && fifo.audio_in_available && !reset;
   end

   assign fifo.read_audio_in = rd;

   // Mono mix and saturating magnitude of the latched stereo pair
   always_comb begin
      mix = ($signed(l_q) >>> 1) + ($signed(r_q) >>> 1);
      if (mix == $signed(NEG_FULL)) begin
         mag_c = POS_FULL;
      end else if (mix[SAMPLE_W-1]) begin
         mag_c = SAMPLE_W'(-mix);
      end else begin
         mag_c = SAMPLE_W'(mix);
      end
   end

   // Next-state logic for sequencing, envelope and onset decision
   always_comb begin
      state_d   = state_q;
      l_d       = l_q;
      r_d       = r_q;
      mag_d     = mag_q;
      peak_d    = peak_q;
      env_d     = env_q;
      onset_d   = 1'b0;
      active_d  = active_q;
      holdoff_d = holdoff_q;
      count_d   = count_q;
      ext_mag   = {1'b0, mag_q};
      ext_env   = {1'b0, env_q};

      case (state_q)
         IDLE: begin
            if (rd) begin
               l_d     = fifo.left_channel_audio_in;
               r_d     = fifo.right_channel_audio_in;
               state_d = MIX;
            end
         end
         MIX: begin
            mag_d = mag_c;
            if (mag_c > peak_q) begin
               peak_d = mag_c;
            end
            state_d = ENV;
         end
         ENV: begin
            if (ext_mag > ext_env) begin
               env_d = SAMPLE_W'(ext_env + ((ext_mag - ext_env) >> ATTACK_SHIFT));
            end else begin
               env_d = SAMPLE_W'(ext_env - ((ext_env - ext_mag) >> RELEASE_SHIFT));
            end
            state_d = DETECT;
         end
         default: begin
            if (!active_q && (env_q >= THRESH_ON) && (holdoff_q == '0)) begin
               onset_d   = 1'b1;
               active_d  = 1'b1;
               holdoff_d = HOLDOFF;
               if (count_q != '1) begin
                  count_d = count_q + 16'd1;
               end
            end else if (holdoff_q != '0) begin
               holdoff_d = holdoff_q - 16'd1;
            end
            if (active_q && (env_q < THRESH_OFF)) begin
               active_d = 1'b0;
            end
            state_d = IDLE;
         end
      endcase

      // Clearing the peak takes priority over a same-cycle update
      if (clear_peak) begin
         peak_d = '0;
      end
   end

   // State registers, all cleared asynchronously
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         l_q       <= '0;
         r_q       <= '0;
         mag_q     <= '0;
         peak_q    <= '0;
         env_q     <= '0;
         onset_q   <= 1'b0;
         active_q  <= 1'b0;
         holdoff_q <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         l_q       <= l_d;
         r_q       <= r_d;
         mag_q     <= mag_d;
         peak_q    <= peak_d;
         env_q     <= env_d;
         onset_q   <= onset_d;
         active_q  <= active_d;
         holdoff_q <= holdoff_d;
         count_q   <= count_d;
      end
   end

   assign onset       = onset_q;
   assign active      = active_q;
   assign envelope    = env_q;
   assign peak_level  = peak_q;
   assign onset_count = count_q;

endmodule

// File: tb/tb_audio_onset_detector.sv
// Self-checking bench for audio_onset_detector: directed scenarios followed
// by randomized samples, compared against a per-sample arithmetic model.
module tb_audio_onset_detector;

   localparam int          ATT  = 2;
   localparam int          REL  = 1;
   localparam int          HOLD = 3;
   localparam longint      T_ON  = 20000000;
   localparam longint      T_OFF = 10000000;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        clear_peak;
   logic        onset;
   logic        active;
   logic [31:0] envelope;
   logic [31:0] peak_level;
   logic [15:0] onset_count;

   audio_onset_detector_if #(.SAMPLE_W(32)) fifo_if ();

   audio_onset_detector #(
      .SAMPLE_W      (32),
      .ATTACK_SHIFT  (ATT),
      .RELEASE_SHIFT (REL),
      .THRESH_ON     (32'd20000000),
      .THRESH_OFF    (32'd10000000),
      .HOLDOFF       (16'(HOLD))
   ) dut (
      .CLOCK_50    (clk),
      .reset       (reset),
      .enable      (enable),
      .clear_peak  (clear_peak),
      .fifo        (fifo_if),
      .onset       (onset),
      .active      (active),
      .envelope    (envelope),
      .peak_level  (peak_level),
      .onset_count (onset_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state, one update per consumed sample
   longint m_env, m_peak;
   int     m_hold, m_count;
   bit     m_active, m_onset;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic longint floor_half(input longint v);
      return (v >= 0) ? v / 2 : -((-v + 1) / 2);
   endfunction

   task automatic model_reset();
      m_env = 0; m_peak = 0; m_hold = 0; m_count = 0;
      m_active = 0; m_onset = 0;
   endtask

   task automatic model_step(input logic [31:0] l, input logic [31:0] r, input bit clr_mix);
      longint mix, mag;
      bit     was_active;
      mix = floor_half(longint'($signed(l))) + floor_half(longint'($signed(r)));
      mag = (mix < 0) ? -mix : mix;
      if (mag > 64'd2147483647) mag = 2147483647;
      if (clr_mix) m_peak = 0;
      else if (mag > m_peak) m_peak = mag;
      if (mag > m_env) m_env = m_env + (mag - m_env) / (64'd1 << ATT);
      else             m_env = m_env - (m_env - mag) / (64'd1 << REL);
      was_active = m_active;
      m_onset = 0;
      if (!m_active && m_env >= T_ON && m_hold == 0) begin
         m_onset = 1; m_active = 1; m_hold = HOLD;
         if (m_count < 65535) m_count++;
      end else if (m_hold != 0) begin
         m_hold--;
      end
      if (was_active && m_env < T_OFF) m_active = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_read"},  32'(fifo_if.read_audio_in), 0);
      chk({tag, "_onset"}, 32'(onset), 0);
      chk({tag, "_act"},   32'(active), 0);
      chk({tag, "_env"},   envelope, 0);
      chk({tag, "_peak"},  peak_level, 0);
      chk({tag, "_cnt"},   32'(onset_count), 0);
   endtask

   // mode: 0 normal, 1 clear_peak during MIX, 2 drop enable during ENV,
   // 3 clear_peak after the peak update
   task automatic do_sample(input logic [31:0] l, input logic [31:0] r, input int mode);
      int waited;
      waited = 0;
      enable = 1'b1;
      fifo_if.audio_in_available = 1'b1;
      fifo_if.left_channel_audio_in  = l;
      fifo_if.right_channel_audio_in = r;
      #1;
      while (!fifo_if.read_audio_in && waited < 8) begin
         @(negedge clk); #1; waited++;
      end
      chk("read_strobe", 32'(fifo_if.read_audio_in), 1);
      model_step(l, r, mode == 1);
      // T+1: MIX; data lines now carry garbage to prove the sample was latched
      @(negedge clk);
      fifo_if.left_channel_audio_in  = $urandom;
      fifo_if.right_channel_audio_in = $urandom;
      if (mode == 1) clear_peak = 1'b1;
      #1;
      chk("read_busy", 32'(fifo_if.read_audio_in), 0);
      chk("onset_width", 32'(onset), 0);
      // T+2: ENV
      @(negedge clk);
      clear_peak = 1'b0;
      if (mode == 2) enable = 1'b0;
      #1;
      chk("peak", peak_level, 32'(m_peak));
      if (mode == 3) clear_peak = 1'b1;
      // T+3: DETECT
      @(negedge clk);
      clear_peak = 1'b0;
      #1;
      chk("envelope", envelope, 32'(m_env));
      if (mode == 3) begin
         m_peak = 0;
         chk("peak_clr", peak_level, 0);
      end
      // T+4: back in IDLE
      @(negedge clk); #1;
      chk("onset", 32'(onset), 32'(m_onset));
      chk("active", 32'(active), 32'(m_active));
      chk("count", 32'(onset_count), 32'(m_count));
      chk("read_next", 32'(fifo_if.read_audio_in), (mode == 2) ? 0 : 1);
      if (mode == 2) begin
         repeat (3) begin
            @(negedge clk); #1;
            chk("read_disabled", 32'(fifo_if.read_audio_in), 0);
         end
      end
      fifo_if.audio_in_available = 1'b0;
      enable = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no_finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ls, rs;
      int guard;
      model_reset();
      reset = 1'b1; enable = 1'b0; clear_peak = 1'b0;
      fifo_if.audio_in_available = 1'b0;
      fifo_if.left_channel_audio_in  = '0;
      fifo_if.right_channel_audio_in = '0;
      #3;
      chk_all_zero("rst");
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      enable = 1'b1;

      // idle with nothing available: no strobe
      repeat (4) begin
         @(negedge clk); #1;
         chk("idle_no_read", 32'(fifo_if.read_audio_in), 0);
      end

      // step input
      repeat (4) do_sample(32'h10000000, 32'h10000000, 0);

      // decay, then holdoff: re-trigger at holdoff 1 is suppressed, next fires
      repeat (10) do_sample(32'h0, 32'h0, 0);
      do_sample(32'd84000000, 32'd84000000, 0);
      do_sample(32'h0, 32'h0, 0);
      do_sample(32'h0, 32'h0, 0);
      do_sample(32'h10000000, 32'h10000000, 0);
      do_sample(32'h10000000, 32'h10000000, 0);

      // hysteresis: hold envelope between the thresholds, then drop below
      guard = 0;
      while (m_env >= T_ON && guard < 40) begin
         do_sample(32'h0, 32'h0, 0);
         guard++;
      end
      repeat (6) do_sample(32'd15000000, 32'd15000000, 0);
      repeat (4) do_sample(32'h0, 32'h0, 0);

      // negative full scale, then clear in the MIX cycle
      do_sample(32'h80000000, 32'h80000000, 0);
      do_sample(32'h80000000, 32'h80000000, 1);
      do_sample(32'h12345678, 32'hF0000000, 3);

      // enable dropped mid-sample
      do_sample(32'h10000000, 32'h10000000, 2);

      // asynchronous reset while in MIX
      @(negedge clk);
      fifo_if.audio_in_available = 1'b1;
      fifo_if.left_channel_audio_in  = 32'h10000000;
      fifo_if.right_channel_audio_in = 32'h10000000;
      #1;
      chk("rst_pre_read", 32'(fifo_if.read_audio_in), 1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk_all_zero("rst_mix");
      @(negedge clk);
      fifo_if.audio_in_available = 1'b0;
      reset = 1'b0;
      model_reset();
      repeat (5) begin
         @(negedge clk); #1;
         chk("post_rst_idle", 32'(fifo_if.read_audio_in), 0);
      end
      chk("post_rst_env", envelope, 0);

      // randomized samples
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 5))
            0: begin ls = 0; rs = 0; end
            1: begin ls = 32'h10000000; rs = 32'h10000000; end
            2: begin ls = $urandom; rs = $urandom; end
            3: begin ls = 32'($signed(32'($urandom_range(0, 32'h07FFFFFF))) - 32'sh04000000);
                     rs = 32'($signed(32'($urandom_range(0, 32'h07FFFFFF))) - 32'sh04000000); end
            4: begin ls = 32'h80000000; rs = 32'h80000000; end
            default: begin ls = 32'($urandom_range(0, 32'h007FFFFF)); rs = ~ls; end
         endcase
         case ($urandom_range(0, 15))
            0:       do_sample(ls, rs, 1);
            1:       do_sample(ls, rs, 3);
            default: do_sample(ls, rs, 0);
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/audio_onset_detector.md
# audio_onset_detector

Consumes microphone samples from the audio codec input FIFO, the read side of the Audio_Controller handshake that the music generator drives on the write side. Each stereo sample is mixed to mono, rectified and smoothed by an attack/release envelope follower. A hysteresis threshold with a holdoff timer turns the envelope into single-cycle step/onset pulses for the game's hit-judging logic. Also exports envelope, peak level and an onset counter for LED display.

## Interface
- SAMPLE_W, 32: width of each codec channel sample (signed two's complement).
- ATTACK_SHIFT, 2: envelope rise coefficient = 2^-ATTACK_SHIFT.
- RELEASE_SHIFT, 8: envelope fall coefficient = 2^-RELEASE_SHIFT.
- THRESH_ON, 32'd20000000: envelope level at or above which an onset fires.
- THRESH_OFF, 32'd10000000: envelope level below which the detector re-arms. Must be less than or equal to THRESH_ON.
- HOLDOFF, 16'd4800: minimum number of samples between onsets (100 ms at 48 kHz).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high; one clock; all state clears immediately.
- enable  in  1  when low, no new samples are read.
- clear_peak  in  1  synchronous clear of peak_level.
- audio_in_available  in  1  codec input FIFO holds a sample.
- left_channel_audio_in  in  SAMPLE_W  left sample, valid while audio_in_available is high.
- right_channel_audio_in  in  SAMPLE_W  right sample, valid while audio_in_available is high.
- read_audio_in  out  1  one-cycle pop strobe to the FIFO.
- onset  out  1  one-cycle pulse per detected onset.
- active  out  1  hysteresis state; high between an onset and re-arm.
- envelope  out  SAMPLE_W  unsigned envelope value.
- peak_level  out  SAMPLE_W  maximum magnitude seen since the last clear.
- onset_count  out  16  total number of onsets; saturates at 16'hFFFF.

## Operation
- The FSM has four states: IDLE → MIX → ENV → DETECT → IDLE. Each state lasts exactly one cycle, except IDLE.
- **IDLE:** when enable && audio_in_available, assert read_audio_in (combinational from state and inputs) and latch L and R in the same cycle, then go to MIX. Otherwise stay in IDLE with read_audio_in = 0.
- **MIX:**
  - mix = (L>>>1) + (R>>>1), signed, cannot overflow.
  - mag = |mix|; the value -2^31 saturates to 2^31-1.
  - peak_level <= max(peak_level, mag). clear_peak in any cycle forces 0 and wins over an update in the same cycle.
- **ENV:** uses 33-bit intermediates with no wrap.
  - If mag > env: env <= env + ((mag-env)>>ATTACK_SHIFT).
  - Otherwise: env <= env - ((env-mag)>>RELEASE_SHIFT).
- **DETECT:** the evaluation uses the holdoff value on entry to DETECT.
  - If !active && env >= THRESH_ON && holdoff == 0: onset <= 1, active <= 1, holdoff <= HOLDOFF, and onset_count increments (saturating).
  - Else if holdoff != 0: holdoff decrements.
  - Independently, if active && env < THRESH_OFF: active <= 0.
  - Return to IDLE.
- Deasserting enable mid-sample does not abort; the in-flight sample completes through DETECT.
- Reset mid-operation discards the in-flight sample. All outputs are 0 and the state is IDLE.

## Timing
- Reset values: read_audio_in, onset, active, envelope, peak_level, onset_count, internal holdoff and FSM state are all 0 / IDLE.
- With read_audio_in in cycle T:
  - peak_level is updated at the T+2 edge.
  - envelope is visible at T+3.
  - onset and active are visible at T+4.
- onset is high for exactly one cycle.
- read_audio_in is never asserted in two consecutive cycles. The minimum spacing is 4 cycles, which gives at most 12.5 M samples/s, far above the codec rate.
- Holdoff is counted in samples, not clocks.

## Test plan
- **Reset:** assert reset asynchronously between clock edges in the MIX state → all outputs read 0 immediately; after release, the next read_audio_in occurs only once audio_in_available = 1.
- **Step input:** L = R = 32'h10000000 held, available = 1 → mag = 268435456; envelope = 67108864 after the first sample; onset pulses once at T+4; onset_count = 1; active = 1. The read strobe recurs every 4 cycles.
- **Holdoff:** HOLDOFF = 3; alternate bursts of loud samples (32'h10000000) and silence (0) long enough to fall below THRESH_OFF, with the re-trigger arriving within 3 samples → second onset suppressed; a re-trigger after 3 or more samples → onset fires.
- **Hysteresis:** ramp env between THRESH_OFF and THRESH_ON after an onset → no new onset and active stays 1; drop below THRESH_OFF → active = 0 one sample later.
- **Negative full scale:** L = R = 32'h80000000 → mag = 32'h7FFFFFFF and peak_level = 32'h7FFFFFFF; clear_peak asserted in the same cycle as the MIX update → peak_level = 0.
- **Enable/flow control:** drop enable in the ENV state → that sample completes, no further read_audio_in. With audio_in_available = 0 and enable = 1 → the FSM stays in IDLE with no strobe.
